board_streamer: RTL and testbench



---
 rtl/board_streamer_pkg.sv | 34 +++
 rtl/board_streamer_cell_mux.sv | 19 +
 rtl/board_streamer.sv | 241 ++++++++++++++++++++++++
 tb/tb_board_streamer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_streamer_pkg.sv
// Shared types and helpers for the board streamer and its cell mux.
package board_streamer_pkg;

  localparam int unsigned GRID    = 9;
  localparam int unsigned CELL_W  = 5;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned NCELLS  = GRID * GRID;
  localparam int unsigned BOARD_W = NCELLS * CELL_W;
  localparam int unsigned OFF_W   = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // One beat of the cell stream as presented to the display back-end.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CELL_W-2:0]  digit;
    logic               revealed;
    logic               cursor;
    logic               error;
    logic               last;
  } beat_t;

  // Bit offset of cell (x,y) inside the packed board; callers keep x,y < GRID.
  function automatic logic [OFF_W-1:0] cell_off(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return OFF_W'(x) * OFF_W'(CELL_W) + OFF_W'(y) * OFF_W'(GRID * CELL_W);
  endfunction

endpackage

// File: rtl/board_streamer_cell_mux.sv
// Combinational 81:1 cell select from a packed board; out-of-range coordinates read as 0.
module board_cell_mux
  import board_streamer_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [CELL_W-1:0]  cell_c
);

  // Select the addressed cell, guarding the part-select against bad coordinates.
  always_comb begin
    cell_c = '0;
    if ((x < COORD_W'(GRID)) && (y < COORD_W'(GRID))) begin
      cell_c = board[cell_off(x, y) +: CELL_W];
    end
  end

endmodule

// File: rtl/board_streamer.sv
// Board streamer: snapshots the game board on request and emits its cells one
// per beat on a valid/ready stream. Optional macro BOARD_STREAMER_DELTA_EN
// streams only cells that changed since the last completed frame.
module board_streamer
  import board_streamer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BOARD_W-1:0] board,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               error,
  input  logic               frame_req,
  output logic               busy,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic [COORD_W-1:0] cell_x,
  output logic [COORD_W-1:0] cell_y,
  output logic [CELL_W-2:0]  cell_digit,
  output logic               cell_revealed,
  output logic               cell_cursor,
  output logic               cell_error,
  output logic               cell_last
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  beat_t              beat_q, beat_d;
  logic [BOARD_W-1:0] snap_board_q, snap_board_d;
  logic [COORD_W-1:0] snap_px_q, snap_px_d;
  logic [COORD_W-1:0] snap_py_q, snap_py_d;
  logic               snap_err_q, snap_err_d;

  logic [BOARD_W-1:0] src_board;
  logic [COORD_W-1:0] src_px, src_py;
  logic               src_err;
  logic               load, done, advance;
  logic [COORD_W-1:0] nx, ny;
  logic [IDX_W-1:0]   nidx, cur_idx;
  logic [CELL_W-1:0]  cell_sel;
  logic               nxt_valid, nxt_last;

`ifdef BOARD_STREAMER_DELTA_EN
  logic [BOARD_W-1:0] ref_board_q, ref_board_d;
  logic [COORD_W-1:0] ref_px_q, ref_px_d;
  logic [COORD_W-1:0] ref_py_q, ref_py_d;
  logic               ref_err_q, ref_err_d;
  logic               have_ref_q, have_ref_d;
  logic [NCELLS-1:0]  chg_vec, later_vec;
  logic               cur_new, cur_ref;
  logic [OFF_W-1:0]   scan_off;
`endif

  // The first beat is built from live inputs because the snapshot lands on the same edge.
  assign src_board = (state_q == IDLE) ? board     : snap_board_q;
  assign src_px    = (state_q == IDLE) ? pos_x     : snap_px_q;
  assign src_py    = (state_q == IDLE) ? pos_y     : snap_py_q;
  assign src_err   = (state_q == IDLE) ? error     : snap_err_q;

  assign nidx    = IDX_W'(ny) * IDX_W'(GRID) + IDX_W'(nx);
  assign cur_idx = IDX_W'(beat_q.y) * IDX_W'(GRID) + IDX_W'(beat_q.x);

  board_cell_mux u_cell_mux (
    .board  (src_board),
    .x      (nx),
    .y      (ny),
    .cell_c (cell_sel)
  );

`ifdef BOARD_STREAMER_DELTA_EN
  // Per-cell change flags against the last completed frame; everything changes before the first one.
  always_comb begin
    chg_vec  = '0;
    cur_new  = 1'b0;
    cur_ref  = 1'b0;
    scan_off = '0;
    for (int unsigned yy = 0; yy < GRID; yy++) begin
      for (int unsigned xx = 0; xx < GRID; xx++) begin
        cur_new  = (COORD_W'(xx) == src_px) && (COORD_W'(yy) == src_py);
        cur_ref  = (COORD_W'(xx) == ref_px_q) && (COORD_W'(yy) == ref_py_q);
        scan_off = cell_off(COORD_W'(xx), COORD_W'(yy));
        chg_vec[IDX_W'(yy * GRID + xx)] =
            !have_ref_q
          || (src_board[scan_off +: CELL_W] != ref_board_q[scan_off +: CELL_W])
          || (cur_new != cur_ref)
          || ((cur_new & src_err) != (cur_ref & ref_err_q));
      end
    end
  end

  // Mask of cells strictly after the one being loaded, for the last-beat look-ahead.
  always_comb begin
    later_vec = '0;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      later_vec[IDX_W'(i)] = (IDX_W'(i) > nidx);
    end
  end

  assign nxt_valid = chg_vec[nidx];
  assign nxt_last  = chg_vec[nidx] && !(|(chg_vec & later_vec));
`else
  assign nxt_valid = 1'b1;
  assign nxt_last  = (nidx == IDX_W'(NCELLS - 1));
`endif

  // Frame sequencing: request capture, beat advance and frame completion.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    snap_board_d = snap_board_q;
    snap_px_d    = snap_px_q;
    snap_py_d    = snap_py_q;
    snap_err_d   = snap_err_q;
    load         = 1'b0;
    done         = 1'b0;
    advance      = 1'b0;
    nx           = '0;
    ny           = '0;
`ifdef BOARD_STREAMER_DELTA_EN
    ref_board_d  = ref_board_q;
    ref_px_d     = ref_px_q;
    ref_py_d     = ref_py_q;
    ref_err_d    = ref_err_q;
    have_ref_d   = have_ref_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_req) begin
          state_d      = STREAM;
          busy_d       = 1'b1;
          snap_board_d = board;
          snap_px_d    = pos_x;
          snap_py_d    = pos_y;
          snap_err_d   = error;
          load         = 1'b1;
        end
      end
      STREAM: begin
        // Skipped (invalid) slots advance unconditionally; real beats wait for ready.
        advance = valid_q ? cell_ready : 1'b1;
        if (advance) begin
          if (beat_q.last || (cur_idx == IDX_W'(NCELLS - 1))) begin
            done    = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
`ifdef BOARD_STREAMER_DELTA_EN
            ref_board_d = snap_board_q;
            ref_px_d    = snap_px_q;
            ref_py_d    = snap_py_q;
            ref_err_d   = snap_err_q;
            have_ref_d  = 1'b1;
`endif
          end else begin
            load = 1'b1;
            if (beat_q.x == COORD_W'(GRID - 1)) begin
              nx = '0;
              ny = beat_q.y + COORD_W'(1);
            end else begin
              nx = beat_q.x + COORD_W'(1);
              ny = beat_q.y;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Build the next output beat from the selected cell.
  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    if (load) begin
      beat_d.x        = nx;
      beat_d.y        = ny;
      beat_d.revealed = cell_sel[CELL_W-1];
      beat_d.digit    = cell_sel[CELL_W-1] ? cell_sel[CELL_W-2:0] : '0;
      beat_d.cursor   = (nx == src_px) && (ny == src_py);
      beat_d.error    = (nx == src_px) && (ny == src_py) && src_err;
      beat_d.last     = nxt_last;
      valid_d         = nxt_valid;
    end else if (done) begin
      beat_d  = '0;
      valid_d = 1'b0;
    end
  end

  // State, snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      beat_q       <= '0;
      snap_board_q <= '0;
      snap_px_q    <= '0;
      snap_py_q    <= '0;
      snap_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      snap_board_q <= snap_board_d;
      snap_px_q    <= snap_px_d;
      snap_py_q    <= snap_py_d;
      snap_err_q   <= snap_err_d;
    end
  end

`ifdef BOARD_STREAMER_DELTA_EN
  // Reference copy of the last completed frame; reset forces the next frame to be full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_board_q <= '0;
      ref_px_q    <= '0;
      ref_py_q    <= '0;
      ref_err_q   <= 1'b0;
      have_ref_q  <= 1'b0;
    end else begin
      ref_board_q <= ref_board_d;
      ref_px_q    <= ref_px_d;
      ref_py_q    <= ref_py_d;
      ref_err_q   <= ref_err_d;
      have_ref_q  <= have_ref_d;
    end
  end
`endif

  assign busy          = busy_q;
  assign cell_valid    = valid_q;
  assign cell_x        = beat_q.x;
  assign cell_y        = beat_q.y;
  assign cell_digit    = beat_q.digit;
  assign cell_revealed = beat_q.revealed;
  assign cell_cursor   = beat_q.cursor;
  assign cell_error    = beat_q.error;
  assign cell_last     = beat_q.last;

endmodule

// File: tb/tb_board_streamer.sv
// Scoreboard bench for board_streamer; follows BOARD_STREAMER_DELTA_EN when defined.
module tb_board_streamer;

  localparam int NC = 81;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] digit;
    logic       rev;
    logic       cur;
    logic       err;
    logic       last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [404:0] board;
  logic [3:0]   pos_x, pos_y;
  logic         error, frame_req;
  logic         busy, cell_valid, cell_ready;
  logic [3:0]   cell_x, cell_y, cell_digit;
  logic         cell_revealed, cell_cursor, cell_error, cell_last;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: last completed frame and the frame currently requested.
  logic [404:0] ref_board = '0;
  logic [3:0]   ref_px = '0, ref_py = '0;
  logic         ref_err = 1'b0, have_ref = 1'b0;
  logic [404:0] pend_b;
  logic [3:0]   pend_px, pend_py;
  logic         pend_e;
  int           last_n;

  always #5 clk = ~clk;

  board_streamer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .board         (board),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .error         (error),
    .frame_req     (frame_req),
    .busy          (busy),
    .cell_valid    (cell_valid),
    .cell_ready    (cell_ready),
    .cell_x        (cell_x),
    .cell_y        (cell_y),
    .cell_digit    (cell_digit),
    .cell_revealed (cell_revealed),
    .cell_cursor   (cell_cursor),
    .cell_error    (cell_error),
    .cell_last     (cell_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] cell_of(input logic [404:0] b, input int x, input int y);
    return b[x*5 + y*45 +: 5];
  endfunction

  function automatic logic [404:0] rand_board();
    logic [404:0] b;
    for (int i = 0; i < 405; i++) b[i] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Model: which cells a frame emits and what each beat carries.
  task automatic push_frame(input logic [404:0] b, input logic [3:0] px, input logic [3:0] py,
                            input logic e, output int n);
    logic [NC-1:0] chg;
    int            last_k;
    exp_t          t;
    logic [4:0]    v;
    logic          cur;
`ifdef BOARD_STREAMER_DELTA_EN
    logic          rcur;
`endif
    n = 0;
    last_k = -1;
    for (int k = 0; k < NC; k++) begin
      v   = cell_of(b, k % 9, k / 9);
      cur = (int'(px) == k % 9) && (int'(py) == k / 9);
`ifdef BOARD_STREAMER_DELTA_EN
      rcur = (int'(ref_px) == k % 9) && (int'(ref_py) == k / 9);
      chg[k] = !have_ref || (v != cell_of(ref_board, k % 9, k / 9)) || (cur != rcur)
               || ((cur & e) != (rcur & ref_err));
`else
      chg[k] = 1'b1;
`endif
      if (chg[k]) begin
        last_k = k;
        n++;
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (chg[k]) begin
        v       = cell_of(b, k % 9, k / 9);
        cur     = (int'(px) == k % 9) && (int'(py) == k / 9);
        t.x     = 4'(k % 9);
        t.y     = 4'(k / 9);
        t.rev   = v[4];
        t.digit = v[4] ? v[3:0] : 4'd0;
        t.cur   = cur;
        t.err   = cur & e;
        t.last  = (k == last_k);
        exp_q.push_back(t);
      end
    end
  endtask

  // Issue a request at the current time (just after a rising edge, DUT idle).
  task automatic start_req(input logic [404:0] b, input logic [3:0] px, input logic [3:0] py,
                           input logic e);
    board = b; pos_x = px; pos_y = py; error = e; frame_req = 1'b1;
    pend_b = b; pend_px = px; pend_py = py; pend_e = e;
    push_frame(b, px, py, e, last_n);
    @(posedge clk); #1;
    frame_req = 1'b0;
    check("req_busy", 32'(busy), 32'd1);
    if (last_n == NC) check("req_first_valid", 32'(cell_valid), 32'd1);
  endtask

  // Run the frame to completion; mode 0 ready high, 1 pattern 1,0,0,1, 2 random.
  task automatic wait_frame(input int mode, input bit disturb);
    int cyc;
    cyc = 0;
    while (busy && cyc < 2000) begin
      case (mode)
        0:       cell_ready = 1'b1;
        1:       cell_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: cell_ready = 1'($urandom_range(0, 1));
      endcase
      if (disturb) begin
        board     = rand_board();
        pos_x     = 4'($urandom_range(0, 15));
        pos_y     = 4'($urandom_range(0, 15));
        error     = ~error;
        frame_req = (cyc >= 5 && cyc < 8);
      end
      @(posedge clk); #1;
      cyc++;
    end
    frame_req = 1'b0;
    if (cyc >= 2000) begin
      errors++; checks++;
      $display("FAIL frame_timeout: busy still %0d after %0d cycles", busy, cyc);
    end
    if (mode == 0 && (last_n == NC || last_n == 0)) check("frame_cycles", 32'(cyc), 32'd81);
    check("frame_leftover", 32'(exp_q.size()), 32'd0);
    check("frame_end_valid", 32'(cell_valid), 32'd0);
    exp_q.delete();
    ref_board = pend_b; ref_px = pend_px; ref_py = pend_py; ref_err = pend_e; have_ref = 1'b1;
  endtask

  // Monitor: pop and compare on each transfer, and hold-check data during stalls.
  exp_t act, held, e_pop;
  bit   stall = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      act = {cell_x, cell_y, cell_digit, cell_revealed, cell_cursor, cell_error, cell_last};
      if (stall) check("stall_hold", {12'd0, cell_valid, act}, {12'd0, 1'b1, held});
      if (cell_valid && cell_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_beat: got %0h with nothing expected at %0t", act, $time);
        end else begin
          e_pop = exp_q.pop_front();
          check("beat", 32'(act), 32'(e_pop));
        end
      end
      stall = cell_valid && !cell_ready;
      held  = act;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [404:0] b;
    reset_n = 1'b0; frame_req = 1'b1; cell_ready = 1'b1;
    board = rand_board(); pos_x = 4'd0; pos_y = 4'd0; error = 1'b0;

    // Reset held two cycles with a pending request.
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(cell_valid), 32'd0);
      check("reset_data", {13'd0, cell_x, cell_y, cell_digit, cell_revealed, cell_cursor,
                           cell_error, cell_last}, 32'd0);
    end
    reset_n = 1'b1;

    // First frame after release, aborted by reset while beat 30 is presented.
    cell_ready = 1'b1;
    start_req(rand_board(), 4'd5, 4'd3, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("abort_at_beat30", {23'd0, cell_valid, cell_x, cell_y}, {23'd0, 1'b1, 4'd3, 4'd3});
    reset_n = 1'b0;
    exp_q.delete();
    have_ref = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", 32'(cell_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_last", 32'(cell_last), 32'd0);
    reset_n = 1'b1;

    // Full frame with known corner cells, ready tied high.
    b = rand_board();
    b[4:0]     = 5'b1_0011;
    b[404:400] = 5'b0_0111;
    start_req(b, 4'd0, 4'd0, 1'b0);
    wait_frame(0, 1'b0);

    // Backpressure pattern, back-to-back with the previous frame.
    start_req(rand_board(), 4'd8, 4'd0, 1'b0);
    wait_frame(1, 1'b0);

    // Cursor/error snapshot with live input changes and requests during busy.
    start_req(rand_board(), 4'd4, 4'd4, 1'b1);
    wait_frame(0, 1'b1);

    // Out-of-range cursor matches no cell.
    start_req(rand_board(), 4'd12, 4'd3, 1'b1);
    wait_frame(2, 1'b0);

    // Random frames with random backpressure.
    for (int i = 0; i < 3; i++) begin
      start_req(rand_board(), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)));
      wait_frame(i % 3, 1'b0);
    end

`ifdef BOARD_STREAMER_DELTA_EN
    // Delta: a single newly revealed cell, then an identical frame.
    b = rand_board();
    b[59] = 1'b0;
    start_req(b, 4'd0, 4'd0, 1'b0);
    wait_frame(0, 1'b0);
    b[59] = 1'b1;
    start_req(b, 4'd0, 4'd0, 1'b0);
    check("delta_one_beat", 32'(last_n), 32'd1);
    wait_frame(0, 1'b0);
    start_req(b, 4'd0, 4'd0, 1'b0);
    check("delta_no_beat", 32'(last_n), 32'd0);
    wait_frame(0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
